// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg: shared types and helpers for the segmented pipelined adder.
// MAX_DATA_W bounds the stage struct; instances narrower than it zero-extend.
package pipe_addsub_pkg;

  localparam int MAX_DATA_W = 64;

  // Width of one carry-linked segment.
  function automatic int seg_w(input int data_w, input int segs);
    return data_w / segs;
  endfunction

  // One carry-propagating pipeline slot: partial sum built so far, the
  // (B already inverted for subtract) operands still to be consumed, and the
  // carry handed to the next segment.
  typedef struct packed {
    logic                  vld;
    logic [MAX_DATA_W-1:0] sum;
    logic [MAX_DATA_W-1:0] a;
    logic [MAX_DATA_W-1:0] b;
    logic                  cy;
  } stage_t;

endpackage

// File: rtl/pipe_addsub_seg.sv
// pipe_addsub_seg: stage K of the pipeline. Adds segment K of the skewed
// operands plus the incoming carry and registers the whole slot.
module pipe_addsub_seg
  import pipe_addsub_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SEGS   = 4,
  parameter int K      = 0
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_en,
  input  stage_t i_st,
  output stage_t o_st
);

  localparam int SEG_W = seg_w(DATA_W, SEGS);
  localparam int LO    = K * SEG_W;

  stage_t           st_d, st_q;
  logic [SEG_W:0]   add;

  // Segment add; everything else in the slot passes through untouched.
  always_comb begin
    add  = {1'b0, i_st.a[LO +: SEG_W]} + {1'b0, i_st.b[LO +: SEG_W]}
         + {{SEG_W{1'b0}}, i_st.cy};
    st_d = st_q;
    if (i_en) begin
      st_d                = i_st;
      st_d.sum[LO +: SEG_W] = add[SEG_W-1:0];
      st_d.cy             = add[SEG_W];
    end
  end

  // Slot register; reset discards whatever beat was in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) st_q <= '0;
    else       st_q <= st_d;
  end

  assign o_st = st_q;

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: SEGS-deep segmented adder/subtractor with valid/ready and
// whole-pipeline stall. Optional signed-overflow flag under the macro
// PIPE_ADDSUB_FLAGS_EN.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SEGS   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout
`ifdef PIPE_ADDSUB_FLAGS_EN
  ,
  output logic              o_ovf
`endif
);

  logic   en;
  stage_t st_in;
  stage_t st_out [SEGS];

  // Everything moves together: only when the output slot is empty or drained.
  assign en          = !o_out_valid || i_out_ready;
  assign o_in_ready  = en;

  // Entry slot: A - B is A + ~B + 1, so invert B and inject i_sub as carry-in.
  always_comb begin
    st_in                = '0;
    st_in.vld            = i_in_valid;
    st_in.a[DATA_W-1:0]  = i_a;
    st_in.b[DATA_W-1:0]  = i_sub ? ~i_b : i_b;
    st_in.cy             = i_sub;
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    if (k == 0) begin : g_first
      pipe_addsub_seg #(.DATA_W(DATA_W), .SEGS(SEGS), .K(k)) u_seg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(en), .i_st(st_in), .o_st(st_out[k])
      );
    end else begin : g_rest
      pipe_addsub_seg #(.DATA_W(DATA_W), .SEGS(SEGS), .K(k)) u_seg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(en), .i_st(st_out[k-1]), .o_st(st_out[k])
      );
    end
  end

  assign o_out_valid = st_out[SEGS-1].vld;
  assign o_sum       = st_out[SEGS-1].sum[DATA_W-1:0];
  assign o_cout      = st_out[SEGS-1].cy;

`ifdef PIPE_ADDSUB_FLAGS_EN
  // Carry into the MSB is a^b^sum at that bit. The last stage registers the
  // operand half (a^b at MSB) next to its segment sum; XOR with the registered
  // sum bit recovers the carry-in, and XOR with carry-out gives overflow.
  stage_t last_in;
  logic   msbx_d, msbx_q;

  if (SEGS == 1) begin : g_last_in1
    assign last_in = st_in;
  end else begin : g_last_inn
    assign last_in = st_out[SEGS-2];
  end

  // Capture operand MSB parity in step with the last stage.
  always_comb begin
    msbx_d = msbx_q;
    if (en) msbx_d = last_in.a[DATA_W-1] ^ last_in.b[DATA_W-1];
  end

  // Flag companion register, cleared with the pipeline.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) msbx_q <= 1'b0;
    else       msbx_q <= msbx_d;
  end

  assign o_ovf = (msbx_q ^ o_sum[DATA_W-1]) ^ o_cout;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and streaming checks for pipe_addsub (64-bit, 4 segs).
module tb_pipe_addsub;

  localparam int DATA_W = 64;
  localparam int SEGS   = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_a = '0;
  logic [DATA_W-1:0] i_b = '0;
  logic              i_sub = 1'b0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [DATA_W-1:0] o_sum;
  logic              o_cout;
`ifdef PIPE_ADDSUB_FLAGS_EN
  logic              o_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [65:0] expq [$];

  pipe_addsub #(.DATA_W(DATA_W), .SEGS(SEGS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_sum(o_sum), .o_cout(o_cout)
`ifdef PIPE_ADDSUB_FLAGS_EN
    , .o_ovf(o_ovf)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [64:0] r;
    logic        ovf;
    if (sub) begin
      r   = {1'b0, a} - {1'b0, b};
      r[64] = (a >= b);
      ovf = (a[63] != b[63]) && (r[63] != a[63]);
    end else begin
      r   = {1'b0, a} + {1'b0, b};
      ovf = (a[63] == b[63]) && (r[63] != a[63]);
    end
    return {ovf, r};
  endfunction

  // Single beat into an empty pipe; checks latency and hand-computed result.
  task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    i_a = a; i_b = b; i_sub = sub; i_in_valid = 1'b1; i_out_ready = 1'b1;
    step();
    i_in_valid = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 65'(lat), 65'(SEGS));
    chk({tag, ".sum"}, {1'b0, o_sum}, {1'b0, es});
    chk({tag, ".cout"}, {64'b0, o_cout}, {64'b0, ec});
`ifdef PIPE_ADDSUB_FLAGS_EN
    chk({tag, ".ovf"}, {64'b0, o_ovf}, {64'b0, eo});
`else
    if (eo === 1'bx) $display("note: %s ovf expectation unknown", tag);
`endif
  endtask

  // Streams n beats; bp=1 toggles i_out_ready randomly.
  task automatic stream(input string tag, input int n, input logic bp);
    int          sent, rcv, cyc;
    logic        held_v, acc;
    logic [64:0] held;
    logic [65:0] e;
    sent = 0; rcv = 0; cyc = 0; held_v = 1'b0; held = '0;
    i_a = {$urandom, $urandom}; i_b = {$urandom, $urandom}; i_sub = 1'($urandom_range(0, 1));
    i_in_valid = 1'b1;
    while (rcv < n && cyc < 5000) begin
      i_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk({tag, ".in_ready"}, {64'b0, o_in_ready}, {64'b0, (!o_out_valid || i_out_ready)});
      if (held_v) begin
        chk({tag, ".hold_vld"}, {64'b0, o_out_valid}, 65'd1);
        chk({tag, ".hold_sum"}, {o_cout, o_sum}, held);
      end
      held_v = o_out_valid && !i_out_ready;
      held   = {o_cout, o_sum};
      if (o_out_valid && i_out_ready) begin
        if (expq.size() == 0) begin
          chk({tag, ".extra"}, 65'd1, 65'd0);
        end else begin
          e = expq.pop_front();
          chk({tag, ".sum"}, {1'b0, o_sum}, {1'b0, e[63:0]});
          chk({tag, ".cout"}, {64'b0, o_cout}, {64'b0, e[64]});
`ifdef PIPE_ADDSUB_FLAGS_EN
          chk({tag, ".ovf"}, {64'b0, o_ovf}, {64'b0, e[65]});
`endif
        end
        rcv++;
      end
      acc = i_in_valid && o_in_ready;
      if (acc) begin
        expq.push_back(model(i_a, i_b, i_sub));
        sent++;
      end
      step();
      if (acc) begin
        if (sent < n) begin
          i_a = {$urandom, $urandom}; i_b = {$urandom, $urandom}; i_sub = 1'($urandom_range(0, 1));
        end else begin
          i_in_valid = 1'b0;
        end
      end
      cyc++;
    end
    chk({tag, ".count"}, 65'(rcv), 65'(n));
    if (!bp) chk({tag, ".cycles"}, 65'(cyc), 65'(n + SEGS));
    i_out_ready = 1'b1;
  endtask

  initial begin
    // Reset held 3 cycles with traffic on the inputs.
    i_rst = 1'b1; i_in_valid = 1'b1; i_a = 64'h1234; i_b = 64'h5678; i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.vld", {64'b0, o_out_valid}, 65'd0);
      chk("rst.sum", {1'b0, o_sum}, 65'd0);
      chk("rst.cout", {64'b0, o_cout}, 65'd0);
    end
    i_rst = 1'b0; i_in_valid = 1'b0;
    step();
    chk("rst.in_ready", {64'b0, o_in_ready}, 65'd1);
    chk("rst.no_pulse", {64'b0, o_out_valid}, 65'd0);

    directed("carry", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
    directed("borrow", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    directed("nobrw", 64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);
    directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step();
    chk("drain.vld", {64'b0, o_out_valid}, 65'd0);

    stream("stream", 100, 1'b0);
    stream("bp", 100, 1'b1);
    step();
    chk("bp.drained", {64'b0, o_out_valid}, 65'd0);

    // Three beats in flight, then reset.
    i_out_ready = 1'b1; i_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_a = 64'(i + 10); i_b = 64'd1; i_in_valid = 1'b1;
      step();
    end
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("midrst.vld_now", {64'b0, o_out_valid}, 65'd0);
    step();
    step();
    i_rst = 1'b0;
    for (int i = 0; i < SEGS + 2; i++) begin
      step();
      chk("midrst.no_vld", {64'b0, o_out_valid}, 65'd0);
    end
    directed("postrst", 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
             64'h0000_0002_0000_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
